// File: rtl/picorv32_ahb_master_if.sv
// ---------------------------------------------------------------------------
// picorv32_ahb_master_if
//
// Bundles the two sides of the PicoRV32 AHB bridge:
//   - FreeAHB-style user interface (ui_*) between the memory adapter and the
//     AHB master: command request/handshake, write data and read data.
//   - AHB 2.0 master signals (h*) between the AHB master and the bus fabric,
//     including the HBUSREQ/HGRANT arbitration pair.
//
// Modports:
//   master : the view of picorv32_ahb_master (consumes ui commands and AHB
//            slave responses, produces handshakes and AHB requests).
//   slave  : the opposite view, used by whatever sits around the master
//            (adapter plus bus fabric, or a testbench).
// ---------------------------------------------------------------------------
interface picorv32_ahb_master_if;

    // User-interface side
    logic        ui_read;
    logic        ui_write;
    logic [31:0] ui_addr;
    logic [2:0]  ui_size;
    logic [3:0]  ui_prot;
    logic        ui_lock;
    logic [31:0] ui_wdata;
    logic        ui_next;
    logic        ui_ready;
    logic        ui_error;
    logic [31:0] ui_rdata;

    // AHB side
    logic        hbusreq;
    logic        hgrant;
    logic        hlock;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hready;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    modport master (
        input  ui_read, ui_write, ui_addr, ui_size, ui_prot, ui_lock, ui_wdata,
        output ui_next, ui_ready, ui_error, ui_rdata,
        output hbusreq, hlock, htrans, haddr, hwrite, hsize, hburst, hprot, hwdata,
        input  hgrant, hready, hresp, hrdata
    );

    modport slave (
        output ui_read, ui_write, ui_addr, ui_size, ui_prot, ui_lock, ui_wdata,
        input  ui_next, ui_ready, ui_error, ui_rdata,
        input  hbusreq, hlock, htrans, haddr, hwrite, hsize, hburst, hprot, hwdata,
        output hgrant, hready, hresp, hrdata
    );

endinterface

// File: rtl/picorv32_ahb_master.sv
// ---------------------------------------------------------------------------
// picorv32_ahb_master
//
// Single-transfer AHB 2.0 bus master driven by the FreeAHB-style user
// interface of the PicoRV32 memory adapter. Every transfer is NONSEQ/SINGLE.
// Handles bus arbitration, wait states, ERROR and RETRY/SPLIT responses and
// (optionally) address alignment checking.
//
// Parameters:
//   MAX_RETRY   : RETRY/SPLIT re-issues allowed before failing with ui_error.
//   CHECK_ALIGN : 1 = misaligned accesses fail at once without bus activity.
//
// Ports:
//   clk    : system clock
//   resetn : asynchronous active-low reset
//   bus    : picorv32_ahb_master_if.master (ui_* handshake and AHB signals)
//
// Latency with hgrant already high and no wait states: ui_ready rises three
// clocks after the clock edge that accepts the command in IDLE.
// ---------------------------------------------------------------------------
module picorv32_ahb_master #(
    parameter int MAX_RETRY   = 15,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input logic                   clk,
    input logic                   resetn,
    picorv32_ahb_master_if.master bus
);

    localparam int              CW          = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [CW-1:0]   RETRY_LIMIT = CW'(MAX_RETRY);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;
    localparam logic [2:0] S_RTY  = 3'd5;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    logic [2:0]    state_q,   state_d;
    logic [31:0]   addr_q,    addr_d;
    logic [2:0]    size_q,    size_d;
    logic [3:0]    prot_q,    prot_d;
    logic          lock_q,    lock_d;
    logic          write_q,   write_d;
    logic          hbusreq_q, hbusreq_d;
    logic          hlock_q,   hlock_d;
    logic [CW-1:0] retry_q,   retry_d;
    logic          issued_q,  issued_d;
    logic          next_q,    next_d;
    logic          ready_q,   ready_d;
    logic          error_q,   error_d;
    logic [31:0]   rdata_q,   rdata_d;

    logic          reject;

    // A command is refused outright for an illegal size, or (when alignment
    // checking is on) for a half/word access not on its natural boundary.
    always_comb begin
        reject = (bus.ui_size > 3'b010);
        if (CHECK_ALIGN) begin
            if ((bus.ui_size == 3'b001) && bus.ui_addr[0])
                reject = 1'b1;
            if ((bus.ui_size == 3'b010) && (bus.ui_addr[1:0] != 2'b00))
                reject = 1'b1;
        end
    end

    // Next-state logic for the transfer FSM and all registered outputs.
    // Handshake pulses default low so each one lasts exactly one cycle.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        prot_d    = prot_q;
        lock_d    = lock_q;
        write_d   = write_q;
        hbusreq_d = hbusreq_q;
        hlock_d   = hlock_q;
        retry_d   = retry_q;
        issued_d  = issued_q;
        next_d    = 1'b0;
        ready_d   = 1'b0;
        error_d   = 1'b0;
        rdata_d   = rdata_q;

        case (state_q)
            S_IDLE: begin
                // While a rejection pulse is visible the client still holds
                // its request, so it must not be taken as a new command.
                if ((bus.ui_read || bus.ui_write) && !next_q) begin
                    addr_d  = bus.ui_addr;
                    size_d  = bus.ui_size;
                    prot_d  = bus.ui_prot;
                    lock_d  = bus.ui_lock;
                    write_d = bus.ui_write;
                    if (reject) begin
                        next_d  = 1'b1;
                        ready_d = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        state_d   = S_REQ;
                        hbusreq_d = 1'b1;
                        hlock_d   = bus.ui_lock;
                    end
                end
            end
            S_REQ: begin
                if (bus.hgrant && bus.hready)
                    state_d = S_ADDR;
            end
            S_ADDR: begin
                // Losing the grant aborts the address phase; re-arbitrate.
                if (!bus.hgrant) begin
                    state_d = S_REQ;
                end else if (bus.hready) begin
                    state_d   = S_DATA;
                    next_d    = !issued_q;
                    issued_d  = 1'b1;
                    hbusreq_d = lock_q;
                end
            end
            S_DATA: begin
                if (bus.hready) begin
                    ready_d = 1'b1;
                    if (bus.hresp == HRESP_OKAY) begin
                        if (!write_q)
                            rdata_d = bus.hrdata;
                    end else begin
                        error_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end else if (bus.hresp == HRESP_ERROR) begin
                    state_d = S_ERR;
                end else if (bus.hresp != HRESP_OKAY) begin
                    state_d = S_RTY;
                end
            end
            S_ERR: begin
                if (bus.hready) begin
                    ready_d = 1'b1;
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_RTY: begin
                if (bus.hready) begin
                    if (retry_q < RETRY_LIMIT) begin
                        retry_d   = retry_q + CW'(1);
                        state_d   = S_REQ;
                        hbusreq_d = 1'b1;
                    end else begin
                        ready_d = 1'b1;
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Every return to IDLE releases the bus and forgets the old command.
        if ((state_d == S_IDLE) && (state_q != S_IDLE)) begin
            hbusreq_d = 1'b0;
            hlock_d   = 1'b0;
            retry_d   = '0;
            issued_d  = 1'b0;
        end
    end

    // State and output registers; reset drops any pending command.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            prot_q    <= '0;
            lock_q    <= 1'b0;
            write_q   <= 1'b0;
            hbusreq_q <= 1'b0;
            hlock_q   <= 1'b0;
            retry_q   <= '0;
            issued_q  <= 1'b0;
            next_q    <= 1'b0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            prot_q    <= prot_d;
            lock_q    <= lock_d;
            write_q   <= write_d;
            hbusreq_q <= hbusreq_d;
            hlock_q   <= hlock_d;
            retry_q   <= retry_d;
            issued_q  <= issued_d;
            next_q    <= next_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.htrans   = (state_q == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.haddr    = addr_q;
    assign bus.hwrite   = write_q;
    assign bus.hsize    = size_q;
    assign bus.hprot    = prot_q;
    assign bus.hburst   = 3'b000;
    assign bus.hbusreq  = hbusreq_q;
    assign bus.hlock    = hlock_q;
    // Write data passes straight through during the data phase only.
    assign bus.hwdata   = ((state_q == S_DATA) && write_q) ? bus.ui_wdata : 32'h0;
    assign bus.ui_next  = next_q;
    assign bus.ui_ready = ready_q;
    assign bus.ui_error = error_q;
    assign bus.ui_rdata = rdata_q;

endmodule

// File: tb/tb_picorv32_ahb_master.sv
// ---------------------------------------------------------------------------
// tb_picorv32_ahb_master
//
// Directed bench for picorv32_ahb_master (MAX_RETRY=2, CHECK_ALIGN=1).
// A cycle-stepped slave model inside run_transfer answers each accepted
// NONSEQ with a scripted sequence of wait states, RETRY or ERROR responses,
// while recording what the master did on both of its interfaces.
// ---------------------------------------------------------------------------
module tb_picorv32_ahb_master;

    logic clk = 1'b0;
    logic resetn;

    picorv32_ahb_master_if busIf();

    picorv32_ahb_master #(
        .MAX_RETRY   (2),
        .CHECK_ALIGN (1'b1)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (busIf)
    );

    always #5 clk = ~clk;

    int passCount  = 0;
    int checkCount = 0;

    // Observations gathered by run_transfer
    int          obsNext, obsReady, obsError, obsNonseq, obsHtransActive, obsBusreq;
    int          obsNextIter, obsReadyIter, obsErrorIter;
    int          obsWdataChecked, obsWdataBad, obsAddrBad;
    logic [31:0] obsRdata;
    logic [2:0]  obsSize;
    logic        obsWrite;
    logic        obsTimeout;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [2:0] size, input logic [31:0] wdata);
        busIf.ui_read  = rd;
        busIf.ui_write = wr;
        busIf.ui_addr  = addr;
        busIf.ui_size  = size;
        busIf.ui_prot  = 4'b0011;
        busIf.ui_lock  = 1'b0;
        busIf.ui_wdata = wdata;
    endtask

    // Steps the bus one cycle at a time acting as the AHB slave.
    // retries < 0 means answer RETRY forever.
    task automatic run_transfer(input int waits, input int retries, input bit errResp,
                                input logic [31:0] rdataVal, input logic [31:0] expAddr,
                                input logic [31:0] expWdata);
        int         slaveSt     = 0;
        int         waitLeft    = 0;
        int         retriesLeft = retries;
        int         doneIter    = -1;
        logic [1:0] respCode    = 2'b00;
        obsNext = 0; obsReady = 0; obsError = 0; obsNonseq = 0;
        obsHtransActive = 0; obsBusreq = 0;
        obsNextIter = -1; obsReadyIter = -1; obsErrorIter = -1;
        obsWdataChecked = 0; obsWdataBad = 0; obsAddrBad = 0;
        obsRdata = 32'h0; obsSize = 3'h7; obsWrite = 1'bx; obsTimeout = 1'b0;
        for (int it = 0; it < 80; it++) begin
            busIf.hrdata = 32'h0;
            case (slaveSt)
                1: begin
                    if (waitLeft > 0) begin
                        busIf.hready = 1'b0; busIf.hresp = 2'b00;
                    end else if (retriesLeft != 0) begin
                        respCode = 2'b10; busIf.hready = 1'b0; busIf.hresp = respCode;
                    end else if (errResp) begin
                        respCode = 2'b01; busIf.hready = 1'b0; busIf.hresp = respCode;
                    end else begin
                        busIf.hready = 1'b1; busIf.hresp = 2'b00; busIf.hrdata = rdataVal;
                    end
                end
                2: begin
                    busIf.hready = 1'b1; busIf.hresp = respCode;
                end
                default: begin
                    busIf.hready = 1'b1; busIf.hresp = 2'b00;
                end
            endcase

            if (busIf.htrans != 2'b00) obsHtransActive++;
            if (busIf.hbusreq) obsBusreq++;
            if (busIf.htrans == 2'b10 && busIf.hready && busIf.hgrant) begin
                obsNonseq++;
                if (busIf.haddr !== expAddr) obsAddrBad++;
                obsSize  = busIf.hsize;
                obsWrite = busIf.hwrite;
            end
            if (slaveSt == 1 && obsWrite === 1'b1) begin
                obsWdataChecked++;
                if (busIf.hwdata !== expWdata) obsWdataBad++;
            end
            if (busIf.ui_next) begin
                obsNext++; obsNextIter = it;
                busIf.ui_read = 1'b0; busIf.ui_write = 1'b0;
            end
            if (busIf.ui_ready) begin
                obsReady++; obsReadyIter = it; obsRdata = busIf.ui_rdata;
                if (doneIter < 0) doneIter = it;
            end
            if (busIf.ui_error) begin
                obsError++; obsErrorIter = it;
            end

            case (slaveSt)
                0: if (busIf.htrans == 2'b10 && busIf.hready && busIf.hgrant) begin
                       slaveSt = 1; waitLeft = waits;
                   end
                1: begin
                    if (waitLeft > 0) waitLeft--;
                    else if (retriesLeft != 0) begin
                        slaveSt = 2;
                        if (retriesLeft > 0) retriesLeft--;
                    end else if (errResp) slaveSt = 2;
                    else slaveSt = 0;
                end
                default: slaveSt = 0;
            endcase

            if (doneIter >= 0 && it >= doneIter + 3) break;
            tick();
        end
        if (doneIter < 0) obsTimeout = 1'b1;
        busIf.hready = 1'b1; busIf.hresp = 2'b00;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        drive_cmd(1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
        busIf.hgrant = 1'b1; busIf.hready = 1'b1; busIf.hresp = 2'b00; busIf.hrdata = 32'h0;
        tick(); tick();
        checkCount++; if (busIf.htrans !== 2'b00 || busIf.hbusreq !== 1'b0 || busIf.hlock !== 1'b0)
            $display("[TB] FAIL reset_bus: htrans=%b hbusreq=%b hlock=%b expected 00/0/0", busIf.htrans, busIf.hbusreq, busIf.hlock);
        else passCount++;
        checkCount++; if (busIf.ui_next !== 1'b0 || busIf.ui_ready !== 1'b0 || busIf.ui_error !== 1'b0)
            $display("[TB] FAIL reset_ui: next=%b ready=%b error=%b expected 0/0/0", busIf.ui_next, busIf.ui_ready, busIf.ui_error);
        else passCount++;
        checkCount++; if (busIf.haddr !== 32'h0 || busIf.hsize !== 3'h0 || busIf.hprot !== 4'h0 || busIf.hwrite !== 1'b0)
            $display("[TB] FAIL reset_addr: haddr=%h hsize=%b hprot=%h hwrite=%b expected zeros", busIf.haddr, busIf.hsize, busIf.hprot, busIf.hwrite);
        else passCount++;
        checkCount++; if (busIf.ui_rdata !== 32'h0 || busIf.hwdata !== 32'h0 || busIf.hburst !== 3'b000)
            $display("[TB] FAIL reset_data: ui_rdata=%h hwdata=%h hburst=%b expected zeros", busIf.ui_rdata, busIf.hwdata, busIf.hburst);
        else passCount++;
        resetn = 1'b1;
        tick(); tick();
        checkCount++; if (busIf.hbusreq !== 1'b0 || busIf.htrans !== 2'b00)
            $display("[TB] FAIL reset_idle: hbusreq=%b htrans=%b expected 0/00", busIf.hbusreq, busIf.htrans);
        else passCount++;
    endtask

    task automatic test_word_read();
        drive_cmd(1'b1, 1'b0, 32'h4000_0000, 3'b010, 32'h0);
        run_transfer(0, 0, 1'b0, 32'hDEAD_BEEF, 32'h4000_0000, 32'h0);
        checkCount++; if (obsTimeout !== 1'b0) $display("[TB] FAIL read_timeout: no ui_ready within budget"); else passCount++;
        checkCount++; if (obsNonseq !== 1 || obsAddrBad !== 0)
            $display("[TB] FAIL read_nonseq: phases=%0d addrBad=%0d expected 1/0", obsNonseq, obsAddrBad); else passCount++;
        checkCount++; if (obsSize !== 3'b010 || obsWrite !== 1'b0)
            $display("[TB] FAIL read_attr: hsize=%b hwrite=%b expected 010/0", obsSize, obsWrite); else passCount++;
        checkCount++; if (obsNext !== 1 || obsNextIter !== 3)
            $display("[TB] FAIL read_next: count=%0d cycle=%0d expected 1/3", obsNext, obsNextIter); else passCount++;
        checkCount++; if (obsReady !== 1 || obsReadyIter !== 4)
            $display("[TB] FAIL read_ready: count=%0d cycle=%0d expected 1/4", obsReady, obsReadyIter); else passCount++;
        checkCount++; if (obsError !== 0) $display("[TB] FAIL read_error: got %0d expected 0", obsError); else passCount++;
        checkCount++; if (obsRdata !== 32'hDEAD_BEEF)
            $display("[TB] FAIL read_rdata: got %h expected deadbeef", obsRdata); else passCount++;
        checkCount++; if (busIf.hbusreq !== 1'b0 || busIf.htrans !== 2'b00)
            $display("[TB] FAIL read_release: hbusreq=%b htrans=%b expected 0/00", busIf.hbusreq, busIf.htrans); else passCount++;
    endtask

    task automatic test_byte_write_waits();
        drive_cmd(1'b0, 1'b1, 32'h0000_0103, 3'b000, 32'h0000_00AA);
        run_transfer(2, 0, 1'b0, 32'h0, 32'h0000_0103, 32'h0000_00AA);
        checkCount++; if (obsTimeout !== 1'b0) $display("[TB] FAIL write_timeout: no ui_ready within budget"); else passCount++;
        checkCount++; if (obsSize !== 3'b000 || obsWrite !== 1'b1 || obsAddrBad !== 0)
            $display("[TB] FAIL write_attr: hsize=%b hwrite=%b addrBad=%0d expected 000/1/0", obsSize, obsWrite, obsAddrBad); else passCount++;
        checkCount++; if (obsWdataChecked !== 3 || obsWdataBad !== 0)
            $display("[TB] FAIL write_hwdata: cycles=%0d bad=%0d expected 3/0", obsWdataChecked, obsWdataBad); else passCount++;
        checkCount++; if (obsReadyIter !== 6 || obsReady !== 1)
            $display("[TB] FAIL write_ready: cycle=%0d count=%0d expected 6/1", obsReadyIter, obsReady); else passCount++;
        checkCount++; if (obsNext !== 1 || obsError !== 0)
            $display("[TB] FAIL write_hs: next=%0d error=%0d expected 1/0", obsNext, obsError); else passCount++;
    endtask

    task automatic test_write_priority();
        drive_cmd(1'b1, 1'b1, 32'h0000_0400, 3'b010, 32'hCAFE_F00D);
        run_transfer(0, 0, 1'b0, 32'h1111_1111, 32'h0000_0400, 32'hCAFE_F00D);
        checkCount++; if (obsWrite !== 1'b1 || obsWdataChecked !== 1 || obsWdataBad !== 0)
            $display("[TB] FAIL prio_write: hwrite=%b cycles=%0d bad=%0d expected 1/1/0", obsWrite, obsWdataChecked, obsWdataBad); else passCount++;
        checkCount++; if (obsReady !== 1 || obsRdata !== 32'hDEAD_BEEF)
            $display("[TB] FAIL prio_rdata: ready=%0d ui_rdata=%h expected 1/deadbeef", obsReady, obsRdata); else passCount++;
    endtask

    task automatic test_misaligned();
        drive_cmd(1'b1, 1'b0, 32'h0000_0102, 3'b010, 32'h0);
        run_transfer(0, 0, 1'b0, 32'h0, 32'h0000_0102, 32'h0);
        checkCount++; if (obsHtransActive !== 0 || obsBusreq !== 0)
            $display("[TB] FAIL align_bus: htransCycles=%0d busreqCycles=%0d expected 0/0", obsHtransActive, obsBusreq); else passCount++;
        checkCount++; if (obsNext !== 1 || obsReady !== 1 || obsError !== 1)
            $display("[TB] FAIL align_count: next=%0d ready=%0d error=%0d expected 1/1/1", obsNext, obsReady, obsError); else passCount++;
        checkCount++; if (obsNextIter !== 1 || obsReadyIter !== 1 || obsErrorIter !== 1)
            $display("[TB] FAIL align_cycle: next=%0d ready=%0d error=%0d expected 1/1/1", obsNextIter, obsReadyIter, obsErrorIter); else passCount++;
        drive_cmd(1'b1, 1'b0, 32'h0000_0101, 3'b001, 32'h0);
        run_transfer(0, 0, 1'b0, 32'h0, 32'h0000_0101, 32'h0);
        checkCount++; if (obsHtransActive !== 0 || obsError !== 1 || obsReady !== 1)
            $display("[TB] FAIL align_half: htransCycles=%0d error=%0d ready=%0d expected 0/1/1", obsHtransActive, obsError, obsReady); else passCount++;
    endtask

    task automatic test_retry_then_okay();
        drive_cmd(1'b1, 1'b0, 32'h0000_0200, 3'b010, 32'h0);
        run_transfer(0, 2, 1'b0, 32'h1234_5678, 32'h0000_0200, 32'h0);
        checkCount++; if (obsNonseq !== 3 || obsAddrBad !== 0)
            $display("[TB] FAIL retry_nonseq: phases=%0d addrBad=%0d expected 3/0", obsNonseq, obsAddrBad); else passCount++;
        checkCount++; if (obsNext !== 1 || obsReady !== 1 || obsError !== 0)
            $display("[TB] FAIL retry_hs: next=%0d ready=%0d error=%0d expected 1/1/0", obsNext, obsReady, obsError); else passCount++;
        checkCount++; if (obsReadyIter !== 12 || obsRdata !== 32'h1234_5678)
            $display("[TB] FAIL retry_data: cycle=%0d ui_rdata=%h expected 12/12345678", obsReadyIter, obsRdata); else passCount++;
    endtask

    task automatic test_retry_exhausted();
        drive_cmd(1'b1, 1'b0, 32'h0000_0200, 3'b010, 32'h0);
        run_transfer(0, -1, 1'b0, 32'h0, 32'h0000_0200, 32'h0);
        checkCount++; if (obsNonseq !== 3)
            $display("[TB] FAIL rtymax_nonseq: phases=%0d expected 3", obsNonseq); else passCount++;
        checkCount++; if (obsNext !== 1 || obsReady !== 1 || obsError !== 1)
            $display("[TB] FAIL rtymax_hs: next=%0d ready=%0d error=%0d expected 1/1/1", obsNext, obsReady, obsError); else passCount++;
        checkCount++; if (obsReadyIter !== 13 || obsErrorIter !== 13)
            $display("[TB] FAIL rtymax_cycle: ready=%0d error=%0d expected 13/13", obsReadyIter, obsErrorIter); else passCount++;
    endtask

    task automatic test_error_response();
        drive_cmd(1'b1, 1'b0, 32'h0000_0300, 3'b010, 32'h0);
        run_transfer(0, 0, 1'b1, 32'h0, 32'h0000_0300, 32'h0);
        checkCount++; if (obsReady !== 1 || obsError !== 1 || obsNext !== 1)
            $display("[TB] FAIL err_hs: ready=%0d error=%0d next=%0d expected 1/1/1", obsReady, obsError, obsNext); else passCount++;
        checkCount++; if (obsReadyIter !== 5 || obsErrorIter !== 5)
            $display("[TB] FAIL err_cycle: ready=%0d error=%0d expected 5/5", obsReadyIter, obsErrorIter); else passCount++;
    endtask

    task automatic test_reset_in_data();
        int seenNext = 0;
        int readyAfter = 0;
        drive_cmd(1'b1, 1'b0, 32'h0000_0300, 3'b010, 32'h0);
        busIf.hready = 1'b1; busIf.hresp = 2'b00;
        for (int i = 0; i < 20 && seenNext == 0; i++) begin
            tick();
            if (busIf.ui_next) seenNext = 1;
        end
        checkCount++; if (seenNext !== 1) $display("[TB] FAIL rst_reach_data: ui_next seen=%0d expected 1", seenNext); else passCount++;
        busIf.ui_read = 1'b0;
        busIf.hready  = 1'b0;
        tick();
        checkCount++; if (busIf.haddr !== 32'h0000_0300)
            $display("[TB] FAIL rst_pre_addr: haddr=%h expected 00000300", busIf.haddr); else passCount++;
        #2 resetn = 1'b0;
        #1;
        checkCount++; if (busIf.haddr !== 32'h0 || busIf.hsize !== 3'h0 || busIf.hprot !== 4'h0 || busIf.htrans !== 2'b00)
            $display("[TB] FAIL rst_async_bus: haddr=%h hsize=%b hprot=%h htrans=%b expected zeros", busIf.haddr, busIf.hsize, busIf.hprot, busIf.htrans); else passCount++;
        checkCount++; if (busIf.hbusreq !== 1'b0 || busIf.ui_next !== 1'b0 || busIf.ui_ready !== 1'b0 || busIf.ui_rdata !== 32'h0)
            $display("[TB] FAIL rst_async_ui: hbusreq=%b next=%b ready=%b rdata=%h expected zeros", busIf.hbusreq, busIf.ui_next, busIf.ui_ready, busIf.ui_rdata); else passCount++;
        @(posedge clk); #1;
        resetn = 1'b1;
        busIf.hready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (busIf.ui_ready) readyAfter++;
        end
        checkCount++; if (readyAfter !== 0)
            $display("[TB] FAIL rst_no_ready: ui_ready pulses=%0d expected 0", readyAfter); else passCount++;
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_byte_write_waits();
        test_write_priority();
        test_misaligned();
        test_retry_then_okay();
        test_retry_exhausted();
        test_error_response();
        test_reset_in_data();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
